imem_prefetch_buffer: RTL and testbench

Sequential instruction prefetcher sitting directly upstream of the fetch stage, between the external instruction memory and the IF/ID path. It issues word reads at consecutive addresses over a req/ack handshake, queues returned instructions with their PCs in a small FIFO, and presents the queue head to the fetch stage. A redirect from decode, on a branch or jump, flushes the queue and restarts prefetch at the new PC.

---
 rtl/imem_prefetch_buffer_pkg.sv | 21 ++
 rtl/imem_prefetch_buffer_if.sv | 27 ++
 rtl/imem_prefetch_buffer_fifo.sv | 71 +++++++
 rtl/imem_prefetch_buffer.sv | 95 +++++++++
 tb/tb_imem_prefetch_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   PC_W        : address / instruction width
//   WORD_BYTES  : sequential fetch stride
//   pf_state_e  : RUN (normal prefetch) / DISCARD (draining an abandoned read)
//   pf_entry_t  : one queued {pc, instr} pair
package prefetch_pkg;
  localparam int PC_W       = 32;
  localparam int WORD_BYTES = 4;
  localparam int ENTRY_W    = 2 * PC_W;

  typedef enum logic {RUN, DISCARD} pf_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] instr;
  } pf_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/imem_prefetch_buffer_if.sv
// Bundles the prefetcher's decode-side and memory-side handshakes.
//   master : the prefetcher (drives fetch_* and mem_req/mem_addr)
//   slave  : the environment (decode redirect, fetch_ready, memory response)
interface imem_prefetch_buffer_if;
  import prefetch_pkg::*;

  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] fetch_instr;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [PC_W-1:0] mem_rdata;

  modport master (
    input  redirect, redirect_pc, fetch_ready, mem_ack, mem_rdata,
    output fetch_valid, fetch_pc, fetch_instr, mem_req, mem_addr
  );

  modport slave (
    output redirect, redirect_pc, fetch_ready, mem_ack, mem_rdata,
    input  fetch_valid, fetch_pc, fetch_instr, mem_req, mem_addr
  );
endinterface

// File: rtl/imem_prefetch_buffer_fifo.sv
// Small synchronous FIFO for prefetched {pc, instr} entries.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full unless popping the same cycle)
//   pop      : drop the head (ignored when empty)
//   clear    : empty the queue; wins over push/pop
//   head     : current head entry, zero when empty
//   count    : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher feeding the fetch stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem_prefetch_buffer_if.master
//              - decode side: redirect/redirect_pc in, fetch_ready in,
//                fetch_valid/fetch_pc/fetch_instr out (queue head)
//              - memory side: mem_req/mem_addr out, mem_ack/mem_rdata in
// One read is outstanding at a time. A redirect that lands while a read is
// pending cannot cancel it on the bus, so the read is parked in DISCARD and
// its data thrown away when it returns.
module imem_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  imem_prefetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);

  pf_state_e       state_q, state_d;
  logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PC_W-1:0] discard_addr_q, discard_addr_d;

  logic [CW-1:0] count;
  pf_entry_t     head, wentry;
  logic          run, full, push, pop, in_flight;

  assign run  = (state_q == RUN);
  assign full = (count == CW'(DEPTH));

  // Full can only be reached through a push, so while a read waits the
  // request stays up and the address stays put.
  assign bus.mem_req  = !rst && (!run || !full);
  assign bus.mem_addr = run ? fetch_addr_q : discard_addr_q;
  assign in_flight    = bus.mem_req && !bus.mem_ack;

  assign bus.fetch_valid = !rst && (count != '0);
  assign bus.fetch_pc    = bus.fetch_valid ? head.pc    : '0;
  assign bus.fetch_instr = bus.fetch_valid ? head.instr : '0;

  // Redirect outranks both queue operations.
  assign pop  = bus.fetch_valid && bus.fetch_ready && !bus.redirect;
  assign push = run && bus.mem_req && bus.mem_ack && !bus.redirect;

  assign wentry = '{pc: fetch_addr_q, instr: bus.mem_rdata};

  always_comb begin
    state_d        = state_q;
    fetch_addr_d   = fetch_addr_q;
    discard_addr_d = discard_addr_q;
    case (state_q)
      RUN: begin
        if (bus.redirect) begin
          fetch_addr_d = word_align(bus.redirect_pc);
          if (in_flight) begin
            discard_addr_d = fetch_addr_q;
            state_d        = DISCARD;
          end
        end else if (push) begin
          fetch_addr_d = fetch_addr_q + PC_W'(WORD_BYTES);
        end
      end
      DISCARD: begin
        if (bus.redirect) fetch_addr_d = word_align(bus.redirect_pc);
        if (bus.mem_ack)  state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      fetch_addr_q   <= RESET_PC;
      discard_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      fetch_addr_q   <= fetch_addr_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (bus.redirect),
    .wdata (wentry),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Randomized bench for imem_prefetch_buffer with a queue-based reference model.
module tb_imem_prefetch_buffer;
  import prefetch_pkg::*;
  localparam int DEPTH = 4;

  logic gclk_unused;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_prefetch_buffer_if bus ();
  imem_prefetch_buffer_if hbus ();

  imem_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  imem_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst(rst), .bus(hbus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: queue of {pc, instr}, next address, pending discard
  logic [63:0] mq[$];
  logic [31:0] m_next = 32'h0;
  bit          m_disc = 1'b0;
  logic [31:0] m_disc_addr = 32'h0;

  // memory responder
  bit          mem_busy = 1'b0;
  int          lat_left = 0;
  int          lat_cfg  = 0;
  bit          last_ack = 1'b0;
  logic [31:0] hi_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic tick(input bit rdy, input bit rd, input logic [31:0] rpc, input bit rs);
    bit          exp_req, exp_vld, ack;
    logic [31:0] exp_pc, exp_in, rdata;
    rst = rs;
    #1;
    exp_req = !rs && (m_disc || mq.size() < DEPTH);
    exp_vld = !rs && mq.size() > 0;
    exp_pc  = exp_vld ? mq[0][63:32] : 32'h0;
    exp_in  = exp_vld ? mq[0][31:0]  : 32'h0;
    chk("mem_req", bus.mem_req, exp_req);
    if (exp_req) chk("mem_addr", bus.mem_addr, m_disc ? m_disc_addr : m_next);
    chk("fetch_valid", bus.fetch_valid, exp_vld);
    chk("fetch_pc", bus.fetch_pc, exp_pc);
    chk("fetch_instr", bus.fetch_instr, exp_in);
    if (bus.fetch_valid === 1'b1)
      chk("instr_vs_pc", bus.fetch_instr, mem_word(bus.fetch_pc));

    ack = 1'b0;
    if (bus.mem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        lat_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      if (lat_left == 0) ack = 1'b1;
      else lat_left--;
    end
    rdata = ack ? mem_word(bus.mem_addr) : $urandom;
    if (ack || rs) mem_busy = 1'b0;
    last_ack = ack;

    bus.fetch_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.mem_ack     = ack;
    bus.mem_rdata   = rdata;

    hbus.fetch_ready = 1'b1;
    hbus.redirect    = 1'b0;
    hbus.redirect_pc = 32'h0;
    hbus.mem_ack     = (hbus.mem_req === 1'b1);
    hbus.mem_rdata   = (hbus.mem_req === 1'b1) ? mem_word(hbus.mem_addr) : 32'h0;
    if (hbus.mem_req === 1'b1 && hi_log.size() < 3) hi_log.push_back(hbus.mem_addr);

    if (rs) begin
      mq.delete();
      m_next = 32'h0;
      m_disc = 1'b0;
    end else if (rd) begin
      if (!m_disc && exp_req && !ack) begin
        m_disc      = 1'b1;
        m_disc_addr = m_next;
      end else if (m_disc && ack) begin
        m_disc = 1'b0;
      end
      mq.delete();
      m_next = {rpc[31:2], 2'b00};
    end else if (m_disc) begin
      if (ack) m_disc = 1'b0;
    end else begin
      if (exp_vld && rdy) void'(mq.pop_front());
      if (ack) begin
        mq.push_back({m_next, rdata});
        m_next = m_next + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acks;
    bit  found;
    bus.fetch_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus.mem_ack = 1'b0;     bus.mem_rdata = 32'h0;
    hbus.fetch_ready = 1'b0; hbus.redirect = 1'b0; hbus.redirect_pc = 32'h0;
    hbus.mem_ack = 1'b0;     hbus.mem_rdata = 32'h0;
    gclk_unused = 1'b0;
    @(posedge clk);
    #1;

    // reset
    repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", bus.fetch_valid, 1'b0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_pc", bus.fetch_pc, 32'h0);
    chk("rst_instr", bus.fetch_instr, 32'h0);

    // streaming with zero-wait memory
    lat_cfg = 0;
    repeat (10) tick(1'b1, 1'b0, 32'h0, 1'b0);

    // RESET_PC near the top of the address space wraps to zero
    chk("hi_log_n", hi_log.size(), 3);
    if (hi_log.size() == 3) begin
      chk("hi_addr0", hi_log[0], 32'hFFFF_FFF8);
      chk("hi_addr1", hi_log[1], 32'hFFFF_FFFC);
      chk("hi_addr2", hi_log[2], 32'h0000_0000);
    end

    // fill to full with fetch stalled
    tick(1'b0, 1'b1, 32'h0, 1'b0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      acks += int'(last_ack);
    end
    chk("fill_acks", acks, 4);
    chk("full_req", bus.mem_req, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("refill_req", bus.mem_req, 1'b1);
    chk("refill_addr", bus.mem_addr, 32'h10);

    // redirect during a slow read to 0x8
    lat_cfg = 3;
    tick(1'b1, 1'b1, 32'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h8 && !mem_busy) found = 1'b1;
      else tick(1'b1, 1'b0, 32'h0, 1'b0);
    end
    chk("slow_req8_seen", found, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr !== 32'h8) found = 1'b1;
      else tick(1'b1, 1'b0, 32'h0, 1'b0);
    end
    chk("disc_next_addr", bus.mem_addr, 32'h100);
    chk("disc_no_queue", bus.fetch_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.fetch_valid === 1'b1) found = 1'b1;
      else tick(1'b1, 1'b0, 32'h0, 1'b0);
    end
    chk("disc_first_valid", found, 1'b1);
    chk("disc_first_pc", bus.fetch_pc, 32'h100);

    // redirect coincident with ack and pop
    lat_cfg = 0;
    repeat (8) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("coinc_pre_valid", bus.fetch_valid, 1'b1);
    tick(1'b1, 1'b1, 32'h40, 1'b0);
    chk("coinc_ack", last_ack, 1'b1);
    chk("coinc_empty", bus.fetch_valid, 1'b0);
    chk("coinc_req", bus.mem_req, 1'b1);
    chk("coinc_addr", bus.mem_addr, 32'h40);

    // reset with two entries and a read in flight
    tick(1'b0, 1'b1, 32'h200, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
    lat_cfg = 3;
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst2_pre_pc", bus.fetch_pc, 32'h200);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst2_req", bus.mem_req, 1'b0);
    chk("rst2_valid", bus.fetch_valid, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst2_addr", bus.mem_addr, 32'h0);

    // reset while discarding
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h4 && !mem_busy) found = 1'b1;
      else tick(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("rst3_req4_seen", found, 1'b1);
    tick(1'b0, 1'b1, 32'h300, 1'b0);
    chk("rst3_disc_addr", bus.mem_addr, 32'h4);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst3_req", bus.mem_req, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst3_addr", bus.mem_addr, 32'h0);
    chk("rst3_valid", bus.fetch_valid, 1'b0);

    // random traffic
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : $urandom;
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, rpc,
           $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
